branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor for the pipelined RV32I core.
- IF stage: looks up the fetch PC in a direct-mapped table and predicts taken/not-taken plus the target for the next fetch.
- EX stage: receives the resolved outcome from the branch-condition unit and the computed target. It flags mispredictions, produces the redirect PC and trains the table.
- Also keeps branch and misprediction statistics counters.

Parameters:
- XLEN, 32, width of PCs and targets.
- INDEX_BITS, 4, log2 of table entries (16); index = pc[INDEX_BITS+1:2].
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_pc  in  XLEN  fetch-stage PC
- pred_taken  out  1  IF prediction (combinational from if_pc and table state)
- pred_target  out  XLEN  next fetch PC per prediction
- ex_valid  in  1  conditional branch present in EX this cycle
- ex_pc  in  XLEN  PC of the EX branch
- ex_pred_taken  in  1  prediction made for this branch in IF, piped down
- ex_pred_target  in  XLEN  predicted target, piped down
- ex_actual_taken  in  1  resolved outcome from the branch-condition unit
- ex_actual_target  in  XLEN  computed branch target (pc + B-immediate)
- mispredict  out  1  combinational flush request to IF/ID
- redirect_pc  out  XLEN  correct next PC when mispredict = 1
- branch_count  out  CNT_W  resolved branches since reset
- mispredict_count  out  CNT_W  mispredictions since reset

Behaviour:
- Entry state:
  - valid (1 bit)
  - tag = pc[XLEN-1:INDEX_BITS+2]
  - target (XLEN bits)
  - 2-bit counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (async, immediate):
  - every valid bit cleared; every counter set to 01; targets and tags set to 0.
  - branch_count and mispredict_count set to 0.
  - Consequences: pred_taken = 0 and pred_target = if_pc+4. mispredict follows the EX inputs, since it is combinational.
- Lookup (zero latency):
  - hit = valid[idx] && tag[idx] == if_pc tag.
  - pred_taken = hit && counter[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc + 4 (modulo 2^XLEN).
- Mispredict (combinational, EX):
  - mispredict = ex_valid && ((ex_pred_taken != ex_actual_taken) || (ex_actual_taken && ex_pred_target != ex_actual_target)).
  - redirect_pc = ex_actual_taken ? ex_actual_target : ex_pc + 4. It is driven every cycle and is meaningful only when mispredict = 1.
- Update (rising edge, only when ex_valid = 1; EX index/tag taken from ex_pc):
  - EX hit, taken: counter saturating +1 (11 stays 11); target <= ex_actual_target.
  - EX hit, not taken: counter saturating -1 (00 stays 00); target unchanged.
  - EX miss, taken: allocate, i.e. valid <= 1, tag <= ex tag, target <= ex_actual_target, counter <= 10 (replaces any old entry).
  - EX miss, not taken: no table change.
  - ex_valid = 0: table unchanged.
- Same-index collision: when IF and EX use the same index in the same cycle, IF sees the pre-update contents. There is no bypass; the new state is visible the next cycle.
- Statistics:
  - branch_count +1 per cycle with ex_valid = 1.
  - mispredict_count +1 per cycle with mispredict = 1.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-operation clears the table and stats immediately; a pending update in that cycle is discarded.
- Non-branch instructions must never assert ex_valid. JAL/JALR are out of scope.

Decomposition:
- Shared package branch_pred_pkg:
  - counter encodings CNT_SNT/CNT_WNT/CNT_WT/CNT_ST.
  - CNT_INIT = CNT_WNT and CNT_ALLOC = CNT_WT.
  - default INDEX_BITS.
- One sub-module, bht_sat_counter: 2-bit saturating next-state logic with inputs cur, taken and output next. The table arrays and stats stay in the top module.

Test Plan:
- Reset, then if_pc = 0x100 -> pred_taken = 0, pred_target = 0x104; both stats counters = 0.
- ex_valid = 1, ex_pc = 0x100, actual taken, target 0x80, ex_pred_taken = 0. Expected that cycle: mispredict = 1, redirect_pc = 0x80. Expected next cycle with if_pc = 0x100: pred_taken = 1, pred_target = 0x80; mispredict_count = 1.
- Same branch resolved not-taken twice, then taken three times -> counter path 10→01→00→01→10→11. pred_taken after each update: 0, 0, 0, 1, 1.
- Alias: with the entry for 0x100 valid, if_pc = 0x140 (same index, different tag) -> pred_taken = 0. Resolving 0x140 taken (target 0x200) replaces the entry; a later lookup of 0x100 misses.
- Predicted taken to 0x80, actual taken to 0x90 -> mispredict = 1, redirect_pc = 0x90, and the entry target updates to 0x90.
- Assert rst asynchronously mid-cycle with ex_valid = 1 -> table and stats cleared at once; after release, lookup of 0x100 gives pred_taken = 0 and branch_count = 0.

Source files
------------

// File: rtl/branch_pred_pkg.sv
// Shared encodings and defaults for the branch predictor and its counter logic.
package branch_pred_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_t;

    localparam cnt_t CNT_INIT  = CNT_WNT;
    localparam cnt_t CNT_ALLOC = CNT_WT;

    localparam int DEFAULT_INDEX_BITS = 4;

endpackage

// File: rtl/bht_sat_counter.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module bht_sat_counter
    import branch_pred_pkg::*;
(
    input  cnt_t cur,
    input  logic taken,
    output cnt_t next
);

    // NOTE: default assignment first so every path drives next and no latch is inferred.
    always_comb begin
        next = cur;
        unique case (cur)
            CNT_SNT: next = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: next = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  next = taken ? CNT_ST  : CNT_WNT;
            CNT_ST:  next = taken ? CNT_ST  : CNT_WT;
            default: next = cur;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: IF-stage lookup, EX-stage
// mispredict detection, table training and branch statistics.
module branch_predictor
    import branch_pred_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    input  logic             ex_actual_taken,
    input  logic [XLEN-1:0]  ex_actual_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = XLEN - INDEX_BITS - 2;

    logic              valid_mem  [ENTRIES];
    logic [TAG_W-1:0]  tag_mem    [ENTRIES];
    logic [XLEN-1:0]   target_mem [ENTRIES];
    cnt_t              cnt_mem    [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]      if_tag;
    logic [TAG_W-1:0]      ex_tag;
    logic                  if_hit;
    logic                  ex_hit;
    cnt_t                  ex_cnt_next;

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign if_tag = if_pc[XLEN-1:INDEX_BITS+2];
    assign ex_idx = ex_pc[INDEX_BITS+1:2];
    assign ex_tag = ex_pc[XLEN-1:INDEX_BITS+2];

    // Lookup reads the registered table, so a same-cycle EX update is not bypassed.
    assign if_hit      = valid_mem[if_idx] && (tag_mem[if_idx] == if_tag);
    assign pred_taken  = if_hit && cnt_mem[if_idx][1];
    assign pred_target = pred_taken ? target_mem[if_idx] : if_pc + XLEN'(4);

    assign ex_hit = valid_mem[ex_idx] && (tag_mem[ex_idx] == ex_tag);

    assign mispredict  = ex_valid &&
                         ((ex_pred_taken != ex_actual_taken) ||
                          (ex_actual_taken && (ex_pred_target != ex_actual_target)));
    assign redirect_pc = ex_actual_taken ? ex_actual_target : ex_pc + XLEN'(4);

    bht_sat_counter u_sat_counter (
        .cur   (cnt_mem[ex_idx]),
        .taken (ex_actual_taken),
        .next  (ex_cnt_next)
    );

    // NOTE: the table is small enough to reset every entry; a reset clears history immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_mem[i]  <= 1'b0;
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
                cnt_mem[i]    <= CNT_INIT;
            end
        end else if (ex_valid) begin
            if (ex_hit) begin
                cnt_mem[ex_idx] <= ex_cnt_next;
                if (ex_actual_taken) begin
                    target_mem[ex_idx] <= ex_actual_target;
                end
            end else if (ex_actual_taken) begin
                valid_mem[ex_idx]  <= 1'b1;
                tag_mem[ex_idx]    <= ex_tag;
                target_mem[ex_idx] <= ex_actual_target;
                cnt_mem[ex_idx]    <= CNT_ALLOC;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (ex_valid && (branch_count != '1)) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_actual_taken;
    logic [31:0] ex_actual_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks   = 0;
    int failures = 0;

    branch_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .ex_actual_taken  (ex_actual_taken),
        .ex_actual_target (ex_actual_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic pt,
                            input logic [31:0] ptgt, input logic at, input logic [31:0] atgt);
        ex_valid         = v;
        ex_pc            = pc;
        ex_pred_taken    = pt;
        ex_pred_target   = ptgt;
        ex_actual_taken  = at;
        ex_actual_target = atgt;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        if_pc = 32'h100;
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken);
        end
        checks++;
        if (pred_target !== 32'h104) begin
            failures++; $display("FAIL reset_pred_target: got %h want 00000104", pred_target);
        end
        checks++;
        if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            failures++; $display("FAIL reset_stats: got %0d/%0d want 0/0", branch_count, mispredict_count);
        end
        checks++;
        if (mispredict !== 1'b0) begin
            failures++; $display("FAIL reset_mispredict: got %b want 0", mispredict);
        end
    endtask

    task automatic test_allocate();
        if_pc = 32'h100;
        drive_ex(1'b1, 32'h100, 1'b0, 32'h104, 1'b1, 32'h80);
        #1;
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin
            failures++; $display("FAIL alloc_mispredict: got %b/%h want 1/00000080", mispredict, redirect_pc);
        end
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++; $display("FAIL alloc_no_bypass: got %b want 0", pred_taken);
        end
        tick();
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
            failures++; $display("FAIL alloc_lookup: got %b/%h want 1/00000080", pred_taken, pred_target);
        end
        checks++;
        if (branch_count !== 32'd1 || mispredict_count !== 32'd1) begin
            failures++; $display("FAIL alloc_stats: got %0d/%0d want 1/1", branch_count, mispredict_count);
        end
    endtask

    // Counter walks 10 -> 01 -> 00 -> 01 -> 10 -> 11.
    task automatic test_counter();
        logic        outcome [5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        pred_in [5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        exp_mis [5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_red [5]  = '{32'h104, 32'h104, 32'h80, 32'h80, 32'h80};
        logic        exp_pred [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        if_pc = 32'h100;
        for (int i = 0; i < 5; i++) begin
            drive_ex(1'b1, 32'h100, pred_in[i], pred_in[i] ? 32'h80 : 32'h104, outcome[i], 32'h80);
            #1;
            checks++;
            if (mispredict !== exp_mis[i] || redirect_pc !== exp_red[i]) begin
                failures++;
                $display("FAIL counter_mis[%0d]: got %b/%h want %b/%h", i, mispredict, redirect_pc, exp_mis[i], exp_red[i]);
            end
            tick();
            drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            #1;
            checks++;
            if (pred_taken !== exp_pred[i]) begin
                failures++; $display("FAIL counter_pred[%0d]: got %b want %b", i, pred_taken, exp_pred[i]);
            end
        end
        checks++;
        if (pred_target !== 32'h80) begin
            failures++; $display("FAIL counter_target: got %h want 00000080", pred_target);
        end
        checks++;
        if (branch_count !== 32'd6 || mispredict_count !== 32'd4) begin
            failures++; $display("FAIL counter_stats: got %0d/%0d want 6/4", branch_count, mispredict_count);
        end
    endtask

    task automatic test_target_mispredict();
        if_pc = 32'h100;
        drive_ex(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h90);
        #1;
        checks++;
        if (mispredict !== 1'b1 || redirect_pc !== 32'h90) begin
            failures++; $display("FAIL tgt_mispredict: got %b/%h want 1/00000090", mispredict, redirect_pc);
        end
        tick();
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h90) begin
            failures++; $display("FAIL tgt_update: got %b/%h want 1/00000090", pred_taken, pred_target);
        end
        checks++;
        if (branch_count !== 32'd7 || mispredict_count !== 32'd5) begin
            failures++; $display("FAIL tgt_stats: got %0d/%0d want 7/5", branch_count, mispredict_count);
        end
    endtask

    task automatic test_alias();
        if_pc = 32'h140;
        #1;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h144) begin
            failures++; $display("FAIL alias_miss: got %b/%h want 0/00000144", pred_taken, pred_target);
        end
        drive_ex(1'b1, 32'h140, 1'b0, 32'h144, 1'b1, 32'h200);
        tick();
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            failures++; $display("FAIL alias_replace: got %b/%h want 1/00000200", pred_taken, pred_target);
        end
        if_pc = 32'h100;
        #1;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            failures++; $display("FAIL alias_evicted: got %b/%h want 0/00000104", pred_taken, pred_target);
        end
    endtask

    task automatic test_back_to_back();
        drive_ex(1'b1, 32'h104, 1'b0, 32'h108, 1'b1, 32'h300);
        tick();
        drive_ex(1'b1, 32'h108, 1'b0, 32'h10c, 1'b1, 32'h400);
        tick();
        drive_ex(1'b0, 32'h200, 1'b0, 32'h204, 1'b1, 32'h500);
        if_pc = 32'h104;
        #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
            failures++; $display("FAIL b2b_first: got %b/%h want 1/00000300", pred_taken, pred_target);
        end
        if_pc = 32'h108;
        #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin
            failures++; $display("FAIL b2b_second: got %b/%h want 1/00000400", pred_taken, pred_target);
        end
        checks++;
        if (mispredict !== 1'b0) begin
            failures++; $display("FAIL idle_mispredict: got %b want 0", mispredict);
        end
        tick();
        checks++;
        if (branch_count !== 32'd10 || mispredict_count !== 32'd8) begin
            failures++; $display("FAIL b2b_stats: got %0d/%0d want 10/8", branch_count, mispredict_count);
        end
        if_pc = 32'h200;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++; $display("FAIL idle_no_update: got %b want 0", pred_taken);
        end
    endtask

    task automatic test_async_reset();
        drive_ex(1'b1, 32'h100, 1'b0, 32'h104, 1'b1, 32'h80);
        if_pc = 32'h104;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            failures++; $display("FAIL areset_stats: got %0d/%0d want 0/0", branch_count, mispredict_count);
        end
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h108) begin
            failures++; $display("FAIL areset_table: got %b/%h want 0/00000108", pred_taken, pred_target);
        end
        checks++;
        if (mispredict !== 1'b1) begin
            failures++; $display("FAIL areset_mispredict_comb: got %b want 1", mispredict);
        end
        tick();
        rst = 1'b0;
        drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        if_pc = 32'h100;
        #1;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104 || branch_count !== 32'd0) begin
            failures++;
            $display("FAIL areset_after: got %b/%h/%0d want 0/00000104/0", pred_taken, pred_target, branch_count);
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_counter();
        test_target_mispredict();
        test_alias();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
